// File: rtl/code_entry_sender.sv
// Keypad-side driver for the number lock: buffers keyed digits, replays them on the
// lock's code bus on ENTER, then reports granted/denied and enforces a failure lockout.
module code_entry_sender #(
  parameter int MAX_DIGITS     = 4,
  parameter int RESP_WAIT      = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             key_valid,
  input  logic [3:0]                       key_digit,
  input  logic                             key_enter,
  input  logic                             key_clear,
  input  logic                             unlock,
  output logic [3:0]                       code,
  output logic                             code_valid,
  output logic                             granted,
  output logic                             denied,
  output logic                             lockout,
  output logic                             busy,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count
);

  localparam int CW    = $clog2(MAX_DIGITS + 1);
  localparam int FW    = $clog2(MAX_FAILS + 1);
  localparam int AW    = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int WW    = $clog2(RESP_WAIT + 1);
  localparam int LW    = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [CW-1:0] MAX_D   = CW'(MAX_DIGITS);
  localparam logic [FW-1:0] MAX_F   = FW'(MAX_FAILS);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RESP_WAIT - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_COLLECT, S_SEND, S_WAIT, S_LOCKOUT} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   idx, idx_d;
  logic [WW-1:0]   wcnt, wcnt_d;
  logic [LW-1:0]   lcnt, lcnt_d;
  logic [3:0]      digit_mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;

  logic [3:0]      code_d;
  logic            code_valid_d, granted_d, denied_d, lockout_d, busy_d;
  logic [FW-1:0]   fail_d, fail_inc;
  logic [CW-1:0]   count_d;

  assign fail_inc = fail_count + FW'(1);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    wcnt_d       = wcnt;
    lcnt_d       = lcnt;
    code_d       = 4'h0;
    code_valid_d = 1'b0;
    granted_d    = 1'b0;
    denied_d     = 1'b0;
    lockout_d    = lockout;
    fail_d       = fail_count;
    count_d      = digit_count;
    mem_we       = 1'b0;
    mem_waddr    = digit_count[AW-1:0];

    unique case (state)
      S_COLLECT: begin
        if (key_clear) begin
          count_d = '0;
        end else begin
          // A digit keyed together with enter is appended before the send starts.
          if (key_valid && (digit_count < MAX_D)) begin
            mem_we  = 1'b1;
            count_d = digit_count + CW'(1);
          end
          if (key_enter && (count_d != '0)) begin
            state_d = S_SEND;
            idx_d   = '0;
          end
        end
      end

      S_SEND: begin
        code_d       = digit_mem[idx[AW-1:0]];
        code_valid_d = 1'b1;
        idx_d        = idx + CW'(1);
        if (idx_d == digit_count) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end

      S_WAIT: begin
        if (unlock) begin
          granted_d = 1'b1;
          fail_d    = '0;
          count_d   = '0;
          state_d   = S_COLLECT;
        end else if (wcnt == WAIT_LAST) begin
          denied_d = 1'b1;
          count_d  = '0;
          fail_d   = fail_inc;
          if (fail_inc == MAX_F) begin
            state_d   = S_LOCKOUT;
            lockout_d = 1'b1;
            lcnt_d    = '0;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          wcnt_d = wcnt + WW'(1);
        end
      end

      S_LOCKOUT: begin
        if (lcnt == LOCK_LAST) begin
          lockout_d = 1'b0;
          fail_d    = '0;
          state_d   = S_COLLECT;
        end else begin
          lcnt_d = lcnt + LW'(1);
        end
      end

      default: state_d = S_COLLECT;
    endcase

    busy_d = (state_d != S_COLLECT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_COLLECT;
      idx         <= '0;
      wcnt        <= '0;
      lcnt        <= '0;
      code        <= 4'h0;
      code_valid  <= 1'b0;
      granted     <= 1'b0;
      denied      <= 1'b0;
      lockout     <= 1'b0;
      busy        <= 1'b0;
      fail_count  <= '0;
      digit_count <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      wcnt        <= wcnt_d;
      lcnt        <= lcnt_d;
      code        <= code_d;
      code_valid  <= code_valid_d;
      granted     <= granted_d;
      denied      <= denied_d;
      lockout     <= lockout_d;
      busy        <= busy_d;
      fail_count  <= fail_d;
      digit_count <= count_d;
    end
  end

  // NOTE: the digit store is not reset; digit_count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (mem_we) digit_mem[mem_waddr] <= key_digit;
  end

endmodule

// File: tb/tb_code_entry_sender.sv
// Self-checking bench for code_entry_sender: directed scenarios plus randomized
// attempts, checked against a queue-based model of buffer contents and fail count.
module tb_code_entry_sender;

  localparam int MAXD = 4;
  localparam int RW   = 4;
  localparam int MAXF = 3;
  localparam int LC   = 16;
  localparam int CW   = $clog2(MAXD + 1);
  localparam int FW   = $clog2(MAXF + 1);

  logic clk = 1'b0;
  logic reset, key_valid, key_enter, key_clear, unlock;
  logic [3:0] key_digit;
  logic [3:0] code;
  logic code_valid, granted, denied, lockout, busy;
  logic [FW-1:0] fail_count;
  logic [CW-1:0] digit_count;

  code_entry_sender #(.MAX_DIGITS(MAXD), .RESP_WAIT(RW), .MAX_FAILS(MAXF),
                      .LOCKOUT_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .key_enter(key_enter), .key_clear(key_clear), .unlock(unlock),
    .code(code), .code_valid(code_valid), .granted(granted), .denied(denied),
    .lockout(lockout), .busy(busy), .fail_count(fail_count), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mq[$];     // model: buffered digits, oldest first
  int mfail = 0; // model: consecutive denials

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; key_digit = 4'h0;
  endtask

  task automatic random_keys();
    key_valid = 1'($urandom); key_enter = 1'($urandom);
    key_clear = 1'($urandom); key_digit = 4'($urandom);
  endtask

  // One COLLECT-state key cycle; the model follows the clear > valid > enter rules.
  task automatic key(input logic v, input logic [3:0] d, input logic e, input logic c);
    logic exp_busy;
    key_valid = v; key_digit = d; key_enter = e; key_clear = c;
    step();
    idle_inputs();
    if (c) mq.delete();
    else if (v && mq.size() < MAXD) mq.push_back(int'(d));
    exp_busy = !c && e && (mq.size() > 0);
    checks++;
    if (digit_count !== CW'(mq.size()) || busy !== exp_busy) begin
      errors++;
      $display("FAIL key: digit_count=%0d busy=%b, expected %0d %b",
               digit_count, busy, mq.size(), exp_busy);
    end
  endtask

  // Follows one attempt right after the enter cycle; d is the window cycle where unlock
  // is raised (-1: never). Stray keys and unlock are driven outside the window.
  task automatic expect_attempt(input int d);
    int n = mq.size();
    for (int i = 0; i < n; i++) begin
      random_keys();
      unlock = 1'($urandom);
      step();
      checks++;
      if (code !== 4'(mq[i]) || code_valid !== 1'b1 || busy !== 1'b1 ||
          granted !== 1'b0 || denied !== 1'b0) begin
        errors++;
        $display("FAIL send[%0d]: code=%h valid=%b busy=%b g=%b d=%b, expected code=%h valid=1 busy=1",
                 i, code, code_valid, busy, granted, denied, 4'(mq[i]));
      end
    end
    for (int w = 0; w < RW; w++) begin
      random_keys();
      unlock = (w == d);
      step();
      unlock = 1'b0;
      checks++;
      if (code !== 4'h0 || code_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_code[%0d]: code=%h valid=%b, expected 0 0", w, code, code_valid);
      end
      if (w == d) begin
        mfail = 0;
        mq.delete();
        checks++;
        if (granted !== 1'b1 || denied !== 1'b0 || busy !== 1'b0 ||
            fail_count !== '0 || digit_count !== '0) begin
          errors++;
          $display("FAIL grant: g=%b d=%b busy=%b fail=%0d cnt=%0d, expected 1 0 0 0 0",
                   granted, denied, busy, fail_count, digit_count);
        end
        idle_inputs();
        return;
      end else if (w == RW - 1) begin
        mfail++;
        mq.delete();
        checks++;
        if (denied !== 1'b1 || granted !== 1'b0 || fail_count !== FW'(mfail) ||
            digit_count !== '0 || lockout !== (mfail == MAXF) || busy !== (mfail == MAXF)) begin
          errors++;
          $display("FAIL deny: d=%b g=%b fail=%0d cnt=%0d lock=%b busy=%b, expected 1 0 %0d 0 %b %b",
                   denied, granted, fail_count, digit_count, lockout, busy, mfail,
                   mfail == MAXF, mfail == MAXF);
        end
      end else begin
        checks++;
        if (granted !== 1'b0 || denied !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL window[%0d]: g=%b d=%b busy=%b, expected 0 0 1", w, granted, denied, busy);
        end
      end
    end
    if (mfail == MAXF) begin
      for (int k = 1; k < LC; k++) begin
        random_keys();
        unlock = 1'($urandom);
        step();
        checks++;
        if (lockout !== 1'b1 || busy !== 1'b1 || fail_count !== FW'(MAXF) ||
            code_valid !== 1'b0 || granted !== 1'b0 || denied !== 1'b0) begin
          errors++;
          $display("FAIL lockout[%0d]: lock=%b busy=%b fail=%0d valid=%b, expected 1 1 %0d 0",
                   k, lockout, busy, fail_count, code_valid, MAXF);
        end
      end
      random_keys();
      step();
      unlock = 1'b0;
      mfail = 0;
      checks++;
      if (lockout !== 1'b0 || busy !== 1'b0 || fail_count !== '0 || digit_count !== '0) begin
        errors++;
        $display("FAIL lockout_exit: lock=%b busy=%b fail=%0d cnt=%0d, expected 0 0 0 0",
                 lockout, busy, fail_count, digit_count);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1; unlock = 1'b0;
    idle_inputs();
    repeat (2) step();
    #2 reset = 1'b0;
    step();
    checks++;
    if (code !== 4'h0 || code_valid !== 1'b0 || granted !== 1'b0 || denied !== 1'b0 ||
        lockout !== 1'b0 || busy !== 1'b0 || fail_count !== '0 || digit_count !== '0) begin
      errors++;
      $display("FAIL reset_state: code=%h v=%b g=%b d=%b l=%b b=%b f=%0d c=%0d, expected all 0",
               code, code_valid, granted, denied, lockout, busy, fail_count, digit_count);
    end
  endtask

  task automatic test_grant();
    key(1, 4'h1, 0, 0); key(1, 4'h0, 0, 0); key(1, 4'h1, 0, 0); key(1, 4'h1, 0, 0);
    key(0, 4'h0, 1, 0);
    expect_attempt(1);
  endtask

  task automatic test_lockout();
    for (int a = 0; a < MAXF; a++) begin
      int n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) key(1, 4'($urandom), 0, 0);
      key(0, 4'h0, 1, 0);
      expect_attempt(-1);
    end
  endtask

  task automatic test_overflow();
    for (int j = 1; j <= 5; j++) key(1, 4'(j), 0, 0);
    key(0, 4'h0, 1, 0);
    expect_attempt(0);
  endtask

  task automatic test_key_with_enter();
    key(1, 4'h3, 0, 0); key(1, 4'h7, 0, 0);
    key(1, 4'h9, 1, 0);
    expect_attempt(RW - 1);
    key(1, 4'h5, 0, 0);
    key(1, 4'h4, 1, 1);
    step();
    checks++;
    if (busy !== 1'b0 || code_valid !== 1'b0 || digit_count !== '0) begin
      errors++;
      $display("FAIL clear_with_key: busy=%b valid=%b cnt=%0d, expected 0 0 0",
               busy, code_valid, digit_count);
    end
  endtask

  task automatic test_empty_enter();
    key(0, 4'h0, 1, 0);
    repeat (2) step();
    checks++;
    if (busy !== 1'b0 || code_valid !== 1'b0 || code !== 4'h0) begin
      errors++;
      $display("FAIL empty_enter: busy=%b valid=%b code=%h, expected 0 0 0", busy, code_valid, code);
    end
  endtask

  task automatic test_reset_mid_send();
    key(1, 4'hA, 0, 0); key(1, 4'hB, 0, 0); key(1, 4'hC, 0, 0);
    key(0, 4'h0, 1, 0);
    step();
    step();
    checks++;
    if (code !== 4'hB || code_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_send: code=%h valid=%b, expected b 1", code, code_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (code !== 4'h0 || code_valid !== 1'b0 || busy !== 1'b0 || digit_count !== '0) begin
      errors++;
      $display("FAIL reset_mid_send: code=%h valid=%b busy=%b cnt=%0d, expected 0 0 0 0",
               code, code_valid, busy, digit_count);
    end
    #3 reset = 1'b0;
    mq.delete();
    mfail = 0;
    step();
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      int n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) key(1, 4'($urandom), 0, 0);
      if ($urandom_range(0, 4) == 0) key(1, 4'($urandom), 1, 0);
      else key(0, 4'h0, 1, 0);
      if (mq.size() > 0) expect_attempt(($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, RW - 1));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_grant();
    test_lockout();
    test_overflow();
    test_key_with_enter();
    test_empty_enter();
    test_reset_mid_send();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
